// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcodes, ALU op encodings and ID/EX control.
// Includes the control decoder used by the decode stage.
package mips_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        AluAdd  = 2'b00,
        AluSub  = 2'b01,
        AluFunc = 2'b10
    } aluop_e;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   alusrc;
        aluop_e aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        regwrite: 1'b0,
        memread:  1'b0,
        memwrite: 1'b0,
        memtoreg: 1'b0,
        alusrc:   1'b0,
        aluop:    AluAdd
    };

    // Unknown opcodes fall through to the bubble so they behave as a NOP.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (op)
            OP_RTYPE: begin
                c.regwrite = 1'b1;
                c.aluop    = AluFunc;
            end
            OP_LW: begin
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.alusrc   = 1'b1;
            end
            OP_SW: begin
                c.memwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            OP_ADDI: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                c.aluop = AluSub;
            end
            default: c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one synchronous write port, $0 hardwired to zero.
// A write in the same cycle as a read of the same register is bypassed to the read port.
module reg_file
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DW-1:0]     rdata1,
    output logic [DW-1:0]     rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DW-1:0]     wdata
);

    logic [DW-1:0] regs_q [NREG];
    logic          wr_en;

    assign wr_en = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wr_en && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wr_en && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file, control decode, early branch resolution,
// load-use/branch hazard stalls and the ID/EX register. ID_STALL_COUNT_EN adds stall_cnt.
module id_stage
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [15:0]       immediate,
    input  logic [5:0]        func,
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DW-1:0]     wb_data,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_dst,
    output logic              eq,
    output logic              jmp,
    output logic              beq,
    output logic              bne,
    output logic              PCwrite,
    output logic              awrite,
    output logic [DW-1:0]     ex_read1,
    output logic [DW-1:0]     ex_read2,
    output logic [DW-1:0]     ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dst,
    output logic [5:0]        ex_func,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic [1:0]        ex_aluop
`ifdef ID_STALL_COUNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic [DW-1:0]     read1;
    logic [DW-1:0]     read2;
    logic [DW-1:0]     imm_ext;
    logic [REG_AW-1:0] dst;
    ctrl_t             ctrl;

    logic is_rtype, is_sw, is_beq, is_bne, is_j, is_branch, rt_used;
    logic load_use, branch_ex, branch_mem, branch_stall, stall;

    logic [DW-1:0]     read1_q, read2_q, imm_q;
    logic [REG_AW-1:0] rs_q, rt_q, dst_q;
    logic [5:0]        func_q;
    ctrl_t             ctrl_q;

    reg_file #(
        .NREG (NREG),
        .DW   (DW)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (read1),
        .rdata2 (read2),
        .we     (wb_write),
        .waddr  (wb_reg),
        .wdata  (wb_data)
    );

    assign ctrl     = decode_ctrl(opcode);
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_bne   = (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);
    assign is_branch = is_beq || is_bne;
    assign rt_used  = is_rtype || is_sw || is_branch;

    assign dst     = is_rtype ? rd : rt;
    assign imm_ext = {{(DW-16){immediate[15]}}, immediate};
    assign eq      = (read1 == read2);

    // Hazard detection against the ID/EX register and the load sitting in MEM.
    always_comb begin
        load_use   = ctrl_q.memread && (dst_q != '0) &&
                     ((dst_q == rs) || ((dst_q == rt) && rt_used));
        branch_ex  = ctrl_q.regwrite && (dst_q != '0) && ((dst_q == rs) || (dst_q == rt));
        branch_mem = mem_memread && (mem_dst != '0) && ((mem_dst == rs) || (mem_dst == rt));
        branch_stall = is_branch && (branch_ex || branch_mem);
        // Reset releases the stall immediately, even mid-cycle.
        stall = (load_use || branch_stall) && !rst;
    end

    always_comb begin
        PCwrite = !stall;
        awrite  = !stall;
        jmp     = is_j && !stall && !rst;
        beq     = is_beq && !stall && !rst;
        bne     = is_bne && !stall && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read1_q <= '0;
            read2_q <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dst_q   <= '0;
            func_q  <= '0;
            ctrl_q  <= CTRL_BUBBLE;
        end else if (stall) begin
            read1_q <= '0;
            read2_q <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dst_q   <= '0;
            func_q  <= '0;
            ctrl_q  <= CTRL_BUBBLE;
        end else begin
            read1_q <= read1;
            read2_q <= read2;
            imm_q   <= imm_ext;
            rs_q    <= rs;
            rt_q    <= rt;
            dst_q   <= dst;
            func_q  <= func;
            ctrl_q  <= ctrl;
        end
    end

    assign ex_read1    = read1_q;
    assign ex_read2    = read2_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_dst      = dst_q;
    assign ex_func     = func_q;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_aluop    = ctrl_q.aluop;

`ifdef ID_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (!PCwrite) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; stall_cnt is exercised when ID_STALL_COUNT_EN is set.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] immediate;
    logic [5:0]  func;
    logic        wb_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mem_memread;
    logic [4:0]  mem_dst;
    logic        eq, jmp, beq, bne, PCwrite, awrite;
    logic [31:0] ex_read1, ex_read2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [5:0]  ex_func;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
    logic [1:0]  ex_aluop;
`ifdef ID_STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage #(
        .NREG (32),
        .DW   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .immediate   (immediate),
        .func        (func),
        .wb_write    (wb_write),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .mem_memread (mem_memread),
        .mem_dst     (mem_dst),
        .eq          (eq),
        .jmp         (jmp),
        .beq         (beq),
        .bne         (bne),
        .PCwrite     (PCwrite),
        .awrite      (awrite),
        .ex_read1    (ex_read1),
        .ex_read2    (ex_read2),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_dst      (ex_dst),
        .ex_func     (ex_func),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_memtoreg (ex_memtoreg),
        .ex_alusrc   (ex_alusrc),
        .ex_aluop    (ex_aluop)
`ifdef ID_STALL_COUNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d, input logic [15:0] imm,
                             input logic [5:0] f);
        opcode    = op;
        rs        = s;
        rt        = t;
        rd        = d;
        immediate = imm;
        func      = f;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0",
                     {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop});
        end
        checks++;
        if ({ex_read1, ex_read2, ex_imm, ex_dst} !== 101'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h/%h want 0", ex_read1, ex_read2, ex_imm, ex_dst);
        end
        checks++;
        if ({PCwrite, awrite, jmp, beq, bne} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_flow got %b want 11000", {PCwrite, awrite, jmp, beq, bne});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addi();
        set_instr(6'h08, 5'd0, 5'd1, 5'd0, 16'd5, 6'd0);
        tick();
        checks++;
        if ({ex_regwrite, ex_alusrc, ex_memread, ex_aluop} !== 5'b11000 || ex_dst !== 5'd1
            || ex_imm !== 32'd5) begin
            errors++;
            $display("FAIL addi got rw/as/mr/op=%b dst=%0d imm=%h want 11000 dst=1 imm=5",
                     {ex_regwrite, ex_alusrc, ex_memread, ex_aluop}, ex_dst, ex_imm);
        end
    endtask

    task automatic test_regfile();
        wb_write = 1'b1;
        wb_reg   = 5'd2;
        wb_data  = 32'h0000_00AA;
        set_instr(6'h00, 5'd2, 5'd0, 5'd9, 16'd0, 6'h20);
        tick();
        checks++;
        if (ex_read1 !== 32'hAA || ex_dst !== 5'd9 || ex_aluop !== 2'b10) begin
            errors++;
            $display("FAIL wb_bypass got read1=%h dst=%0d aluop=%b want AA 9 10",
                     ex_read1, ex_dst, ex_aluop);
        end
        wb_write = 1'b0;
        set_instr(6'h00, 5'd0, 5'd2, 5'd9, 16'd0, 6'h20);
        tick();
        checks++;
        if (ex_read2 !== 32'hAA || ex_func !== 6'h20) begin
            errors++;
            $display("FAIL rf_stored got read2=%h func=%h want AA 20", ex_read2, ex_func);
        end
        wb_write = 1'b1;
        wb_reg   = 5'd0;
        wb_data  = 32'hDEAD_BEEF;
        set_instr(6'h00, 5'd0, 5'd0, 5'd9, 16'd0, 6'h20);
        tick();
        checks++;
        if (ex_read1 !== 32'd0) begin
            errors++;
            $display("FAIL r0_bypass got %h want 0", ex_read1);
        end
        wb_write = 1'b0;
        tick();
        checks++;
        if (ex_read1 !== 32'd0 || ex_read2 !== 32'd0) begin
            errors++;
            $display("FAIL r0_stored got %h/%h want 0/0", ex_read1, ex_read2);
        end
    endtask

    task automatic test_load_use();
        set_instr(6'h23, 5'd0, 5'd3, 5'd0, 16'd0, 6'd0);
        #1;
        checks++;
        if (PCwrite !== 1'b1) begin
            errors++;
            $display("FAIL lw_issue_stall got PCwrite=%b want 1", PCwrite);
        end
        tick();
        checks++;
        if ({ex_memread, ex_memtoreg, ex_regwrite, ex_alusrc} !== 4'b1111 || ex_dst !== 5'd3) begin
            errors++;
            $display("FAIL lw_decode got %b dst=%0d want 1111 dst=3",
                     {ex_memread, ex_memtoreg, ex_regwrite, ex_alusrc}, ex_dst);
        end
        set_instr(6'h00, 5'd3, 5'd5, 5'd4, 16'd0, 6'h20);
        #1;
        checks++;
        if ({PCwrite, awrite} !== 2'b00) begin
            errors++;
            $display("FAIL load_use_stall got %b want 00", {PCwrite, awrite});
        end
        tick();
        checks++;
        if ({ex_regwrite, ex_memread, ex_dst, ex_read1} !== 39'd0 || {PCwrite, awrite} !== 2'b11)
        begin
            errors++;
            $display("FAIL load_use_bubble got rw=%b mr=%b dst=%0d pc/aw=%b want 0 0 0 11",
                     ex_regwrite, ex_memread, ex_dst, {PCwrite, awrite});
        end
        tick();
        checks++;
        if (ex_regwrite !== 1'b1 || ex_dst !== 5'd4 || ex_rs !== 5'd3 || ex_rt !== 5'd5) begin
            errors++;
            $display("FAIL load_use_issue got rw=%b dst=%0d rs=%0d rt=%0d want 1 4 3 5",
                     ex_regwrite, ex_dst, ex_rs, ex_rt);
        end
    endtask

    task automatic test_branch();
        set_instr(6'h3F, 5'd0, 5'd0, 5'd0, 16'd0, 6'd0);
        wb_write = 1'b1;
        wb_reg   = 5'd6;
        wb_data  = 32'd1;
        tick();
        wb_reg  = 5'd7;
        wb_data = 32'd2;
        tick();
        wb_write = 1'b0;
        set_instr(6'h04, 5'd6, 5'd6, 5'd0, 16'd0, 6'd0);
        #1;
        checks++;
        if ({eq, beq, bne, PCwrite} !== 4'b1101) begin
            errors++;
            $display("FAIL beq_taken got eq/beq/bne/pc=%b want 1101", {eq, beq, bne, PCwrite});
        end
        tick();
        checks++;
        if (ex_aluop !== 2'b01 || ex_regwrite !== 1'b0) begin
            errors++;
            $display("FAIL beq_ctrl got aluop=%b rw=%b want 01 0", ex_aluop, ex_regwrite);
        end
        set_instr(6'h05, 5'd6, 5'd7, 5'd0, 16'd0, 6'd0);
        #1;
        checks++;
        if ({eq, beq, bne} !== 3'b001) begin
            errors++;
            $display("FAIL bne_flags got eq/beq/bne=%b want 001", {eq, beq, bne});
        end
        tick();
        set_instr(6'h02, 5'd0, 5'd0, 5'd0, 16'd0, 6'd0);
        #1;
        checks++;
        if ({jmp, PCwrite, beq, bne} !== 4'b1100) begin
            errors++;
            $display("FAIL jmp got jmp/pc/beq/bne=%b want 1100", {jmp, PCwrite, beq, bne});
        end
        tick();
    endtask

    task automatic test_load_branch();
        set_instr(6'h23, 5'd0, 5'd8, 5'd0, 16'd0, 6'd0);
        tick();
        set_instr(6'h04, 5'd8, 5'd0, 5'd0, 16'd0, 6'd0);
        #1;
        checks++;
        if ({PCwrite, awrite, beq} !== 3'b000) begin
            errors++;
            $display("FAIL lb_stall1 got pc/aw/beq=%b want 000", {PCwrite, awrite, beq});
        end
        tick();
        mem_memread = 1'b1;
        mem_dst     = 5'd8;
        #1;
        checks++;
        if ({PCwrite, beq, ex_memread} !== 3'b000) begin
            errors++;
            $display("FAIL lb_stall2 got pc/beq/mr=%b want 000", {PCwrite, beq, ex_memread});
        end
        tick();
        mem_memread = 1'b0;
        mem_dst     = 5'd0;
        #1;
        checks++;
        if ({PCwrite, beq, eq} !== 3'b111) begin
            errors++;
            $display("FAIL lb_release got pc/beq/eq=%b want 111", {PCwrite, beq, eq});
        end
        tick();
    endtask

    task automatic test_imm_nop();
        set_instr(6'h08, 5'd0, 5'd1, 5'd0, 16'hFFFF, 6'd0);
        tick();
        checks++;
        if (ex_imm !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sign_ext got %h want FFFFFFFF", ex_imm);
        end
        set_instr(6'h2B, 5'd0, 5'd1, 5'd0, 16'd4, 6'd0);
        tick();
        checks++;
        if ({ex_memwrite, ex_alusrc, ex_regwrite, ex_memread} !== 4'b1100) begin
            errors++;
            $display("FAIL sw_decode got %b want 1100",
                     {ex_memwrite, ex_alusrc, ex_regwrite, ex_memread});
        end
        set_instr(6'h3F, 5'd1, 5'd1, 5'd1, 16'd0, 6'd0);
        #1;
        checks++;
        if (PCwrite !== 1'b1) begin
            errors++;
            $display("FAIL nop_stall got PCwrite=%b want 1", PCwrite);
        end
        tick();
        checks++;
        if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop} !== 7'd0) begin
            errors++;
            $display("FAIL nop_ctrl got %b want 0",
                     {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop});
        end
    endtask

    task automatic test_reset_mid_stall();
        set_instr(6'h23, 5'd0, 5'd3, 5'd0, 16'd0, 6'd0);
        tick();
        set_instr(6'h00, 5'd3, 5'd5, 5'd4, 16'd0, 6'h20);
        #1;
        checks++;
        if (PCwrite !== 1'b0) begin
            errors++;
            $display("FAIL mid_stall_pre got PCwrite=%b want 0", PCwrite);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({PCwrite, awrite, ex_memread, ex_regwrite} !== 4'b1100 || ex_dst !== 5'd0) begin
            errors++;
            $display("FAIL mid_stall_rst got pc/aw/mr/rw=%b dst=%0d want 1100 0",
                     {PCwrite, awrite, ex_memread, ex_regwrite}, ex_dst);
        end
        tick();
        rst = 1'b0;
        set_instr(6'h3F, 5'd0, 5'd0, 5'd0, 16'd0, 6'd0);
        tick();
    endtask

`ifdef ID_STALL_COUNT_EN
    task automatic test_stall_cnt();
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cnt_reset got %0d want 0", stall_cnt);
        end
        set_instr(6'h23, 5'd0, 5'd3, 5'd0, 16'd0, 6'd0);
        tick();
        set_instr(6'h00, 5'd3, 5'd5, 5'd4, 16'd0, 6'h20);
        tick();
        tick();
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL cnt_load_use got %0d want 1", stall_cnt);
        end
        set_instr(6'h23, 5'd0, 5'd8, 5'd0, 16'd0, 6'd0);
        tick();
        set_instr(6'h04, 5'd8, 5'd0, 5'd0, 16'd0, 6'd0);
        tick();
        mem_memread = 1'b1;
        mem_dst     = 5'd8;
        tick();
        mem_memread = 1'b0;
        mem_dst     = 5'd0;
        tick();
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL cnt_branch got %0d want 3", stall_cnt);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        wb_write    = 1'b0;
        wb_reg      = '0;
        wb_data     = '0;
        mem_memread = 1'b0;
        mem_dst     = '0;
        set_instr(6'h00, 5'd0, 5'd0, 5'd0, 16'd0, 6'd0);
        test_reset();
        test_addi();
        test_regfile();
        test_load_use();
        test_branch();
        test_load_branch();
        test_imm_nop();
        test_reset_mid_stall();
`ifdef ID_STALL_COUNT_EN
        test_stall_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
